// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the external SRAM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 19;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Active-low SRAM control strobes, kept together so they reset as one bundle.
  typedef struct packed {
    logic cs_n;
    logic oe_n;
    logic we_n;
  } strobe_t;

  localparam strobe_t STROBE_RST = '{cs_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};

endpackage

// File: rtl/sram_arb_grant.sv
// Two-way combinational grant for the SRAM arbiter.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller only samples the grant while idle.
//
// Ports: req0/req1 requests in; last = port granted most recently (only with
// SRAM_ARB_ROUND_ROBIN_EN); gnt_any = some port wins; gnt_sel = winning port.
// Macro SRAM_ARB_ROUND_ROBIN_EN: defined -> round robin, undefined -> port 0
// has fixed priority and the last-grant input does not exist.
module sram_arb_grant (
  input  logic req0,
  input  logic req1,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  input  logic last,
`endif
  output logic gnt_any,
  output logic gnt_sel
);

  always_comb begin
    gnt_any = req0 | req1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // On contention the port that did not win last time goes next.
    gnt_sel = (req0 && req1) ? ~last : req1;
`else
    gnt_sel = req1 & ~req0;
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and CS/OE/WE cycle sequencer for a 512Kx16 async SRAM.
// Latency: request to ack is WAIT_CYCLES+2 cycles; one idle cycle between accesses.
// Backpressure: requesters hold req until their one-cycle ack; the loser waits.
//
// Ports: clk/rst (async active-high); req/we/addr/wdata per port in; ack0/ack1
// pulses and shared rdata out; sram_adr/sram_dat_out/sram_dat_oe and active-low
// strobes to the pads, sram_dat_in from the pads. All outputs are registered.
// Macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_adr,
  output logic [DATA_W-1:0] sram_dat_out,
  output logic              sram_dat_oe,
  input  logic [DATA_W-1:0] sram_dat_in,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_arbiter: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t              state, nxt_state;
  logic [3:0]          cnt;
  logic                gnt_any, gnt_sel;
  logic                lat_we, lat_port;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                cur_we;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  strobe_t             strobe, strobe_d;
  logic                dat_oe_d, ack0_d, ack1_d;
  logic [ADDR_W-1:0]   adr_d;
  logic [DATA_W-1:0]   dat_out_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_gnt;
`endif

  sram_arb_grant u_grant (
    .req0    (req0),
    .req1    (req1),
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    .last    (last_gnt),
`endif
    .gnt_any (gnt_any),
    .gnt_sel (gnt_sel)
  );

  // While idle the winner's inputs feed the SETUP outputs directly, because
  // they are latched on the same edge that enters SETUP.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == IDLE) begin
      cur_we    = gnt_sel ? we1    : we0;
      cur_addr  = gnt_sel ? addr1  : addr0;
      cur_wdata = gnt_sel ? wdata1 : wdata0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // FSM: next state
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (gnt_any) nxt_state = SETUP;
      SETUP:   nxt_state = ACCESS;
      ACCESS:  if (cnt == 4'd0) nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // FSM: outputs, decoded from the next state so they can be registered.
  always_comb begin
    strobe_d  = STROBE_RST;
    dat_oe_d  = 1'b0;
    adr_d     = sram_adr;
    dat_out_d = sram_dat_out;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    case (nxt_state)
      SETUP: begin
        strobe_d.cs_n = 1'b0;
        strobe_d.oe_n = cur_we;
        adr_d         = cur_addr;
        dat_oe_d      = cur_we;
        if (cur_we) dat_out_d = cur_wdata;
      end
      ACCESS: begin
        strobe_d.cs_n = 1'b0;
        strobe_d.oe_n = lat_we;
        strobe_d.we_n = ~lat_we;
        dat_oe_d      = lat_we;
      end
      DONE: begin
        // Address and data drive stay put after WE rises for write hold time.
        dat_oe_d = lat_we;
        ack0_d   = ~lat_port;
        ack1_d   = lat_port;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we       <= 1'b0;
      lat_port     <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      cnt          <= 4'd0;
      rdata        <= '0;
      strobe       <= STROBE_RST;
      sram_dat_oe  <= 1'b0;
      sram_adr     <= '0;
      sram_dat_out <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
    end else begin
      if (state == IDLE && gnt_any) begin
        lat_we    <= cur_we;
        lat_port  <= gnt_sel;
        lat_addr  <= cur_addr;
        lat_wdata <= cur_wdata;
      end
      if (state == SETUP)
        cnt <= CNT_LOAD;
      else if (state == ACCESS && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (state == ACCESS && cnt == 4'd0 && !lat_we)
        rdata <= sram_dat_in;
      strobe       <= strobe_d;
      sram_dat_oe  <= dat_oe_d;
      sram_adr     <= adr_d;
      sram_dat_out <= dat_out_d;
      ack0         <= ack0_d;
      ack1         <= ack1_d;
    end
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       last_gnt <= 1'b1;
    else if (state == IDLE && gnt_any) last_gnt <= gnt_sel;
  end
`endif

  assign sram_cs_n = strobe.cs_n;
  assign sram_oe_n = strobe.oe_n;
  assign sram_we_n = strobe.we_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: three instances (WAIT_CYCLES 2, 1, 15),
// each with a small SRAM model; stimulus pushes expected acks, a monitor pops
// and compares them, including strobe widths and address stability.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2:0]       req0, req1, we0, we1, ack0, ack1;
  logic [2:0]       sram_dat_oe, cs_n, oe_n, we_n;
  logic [2:0][18:0] addr0, addr1, sram_adr;
  logic [2:0][15:0] wdata0, wdata1, rdata, sram_dat_out, sram_dat_in;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    logic [15:0] mem [32];

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst),
      .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]),
      .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
      .ack0(ack0[g]), .ack1(ack1[g]), .rdata(rdata[g]),
      .sram_adr(sram_adr[g]), .sram_dat_out(sram_dat_out[g]),
      .sram_dat_oe(sram_dat_oe[g]), .sram_dat_in(sram_dat_in[g]),
      .sram_cs_n(cs_n[g]), .sram_oe_n(oe_n[g]), .sram_we_n(we_n[g])
    );

    assign sram_dat_in[g] = !oe_n[g] ? mem[sram_adr[g][4:0]] : 16'hDEAD;
    always @(posedge clk)
      if (!cs_n[g] && !we_n[g]) mem[sram_adr[g][4:0]] <= sram_dat_out[g];
  end

  typedef struct {
    int          inst;
    int          port;
    bit          we;
    int          cyc;   // expected ack cycle, -1 = not timed
    logic [18:0] adr;
    logic [15:0] dat;   // write data, or expected read data
  } exp_t;

  exp_t sb[$];

  function automatic int wc(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 15;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int          we_lo[3], oe_lo[3], doe[3];
  bit          adr_bad[3], clash[3], cs_seen[3];
  logic [18:0] adr_hold[3];
  logic [15:0] wd_seen[3];
  int          idx;
  exp_t        e;

  function automatic void clr(int i);
    we_lo[i] = 0; oe_lo[i] = 0; doe[i] = 0;
    adr_bad[i] = 0; clash[i] = 0; cs_seen[i] = 0;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) clr(i);
      else begin
        if (!cs_n[i]) begin
          if (cs_seen[i] && sram_adr[i] != adr_hold[i]) adr_bad[i] = 1;
          cs_seen[i]  = 1;
          adr_hold[i] = sram_adr[i];
        end
        if (!oe_n[i] && sram_dat_oe[i]) clash[i] = 1;
        if (!we_n[i]) begin we_lo[i]++; wd_seen[i] = sram_dat_out[i]; end
        if (!oe_n[i]) oe_lo[i]++;
        if (sram_dat_oe[i]) doe[i]++;
        if (ack0[i] || ack1[i]) begin
          idx = -1;
          foreach (sb[k]) if (idx < 0 && sb[k].inst == i) idx = k;
          if (idx < 0) chk($sformatf("i%0d_unexpected_ack", i), 1, 0);
          else begin
            e = sb[idx];
            sb.delete(idx);
            chk($sformatf("i%0d_ack_port", i), {ack1[i], ack0[i]}, (e.port == 1) ? 2 : 1);
            if (e.cyc >= 0) chk($sformatf("i%0d_ack_cycle", i), cyc, e.cyc);
            if (!e.we) chk($sformatf("i%0d_rdata", i), rdata[i], e.dat);
            else       chk($sformatf("i%0d_wr_data", i), wd_seen[i], e.dat);
            chk($sformatf("i%0d_we_low_cycles", i), we_lo[i], e.we ? wc(i) : 0);
            chk($sformatf("i%0d_oe_low_cycles", i), oe_lo[i], e.we ? 0 : wc(i) + 1);
            chk($sformatf("i%0d_dat_oe_cycles", i), doe[i], e.we ? wc(i) + 2 : 0);
            chk($sformatf("i%0d_addr", i), adr_hold[i], e.adr);
            chk($sformatf("i%0d_addr_stable", i), adr_bad[i], 0);
            chk($sformatf("i%0d_oe_doe_clash", i), clash[i], 0);
          end
          clr(i);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(int i, int port, bit we, logic [18:0] a, logic [15:0] d);
    sb.push_back('{inst: i, port: port, we: we, cyc: cyc + wc(i) + 2, adr: a, dat: d});
    if (port == 0) begin
      req0[i] = 1'b1; we0[i] = we; addr0[i] = a; wdata0[i] = we ? d : 16'h0;
    end else begin
      req1[i] = 1'b1; we1[i] = we; addr1[i] = a; wdata1[i] = we ? d : 16'h0;
    end
  endtask

  task automatic wait_ack(int i, int port);
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if ((port == 0) ? ack0[i] : ack1[i]) break;
      n++;
    end
    chk($sformatf("i%0d_p%0d_ack_seen", i, port), int'(n < 40), 1);
    if (port == 0) req0[i] = 1'b0; else req1[i] = 1'b0;
  endtask

  task automatic do_acc(int i, int port, bit we, logic [18:0] a, logic [15:0] d);
    @(negedge clk);
    issue(i, port, we, a, d);
    wait_ack(i, port);
  endtask

  initial begin : stim
    int n0, n1, cs_lo, budget;
    rst = 1'b1;
    req0 = '0; req1 = '0; we0 = '0; we1 = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);

    chk("rst_ack0", ack0[0], 0);
    chk("rst_ack1", ack1[0], 0);
    chk("rst_rdata", rdata[0], 0);
    chk("rst_adr", sram_adr[0], 0);
    chk("rst_dat_out", sram_dat_out[0], 0);
    chk("rst_dat_oe", sram_dat_oe[0], 0);
    chk("rst_cs_n", cs_n[0], 1);
    chk("rst_oe_n", oe_n[0], 1);
    chk("rst_we_n", we_n[0], 1);
    rst = 1'b0;
    @(negedge clk);

    // Basic write on port 0, then read back on port 1.
    do_acc(0, 0, 1'b1, 19'h00010, 16'hA5A5);
    do_acc(0, 1, 1'b0, 19'h00010, 16'hA5A5);

    // Both ports held for 20 accesses.
    @(negedge clk);
    for (int k = 0; k < 20; k++)
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      sb.push_back('{inst: 0, port: k % 2, we: 1'b0, cyc: -1, adr: 19'h00010, dat: 16'hA5A5});
`else
      sb.push_back('{inst: 0, port: 0, we: 1'b0, cyc: -1, adr: 19'h00010, dat: 16'hA5A5});
`endif
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 19'h00010;
    req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 19'h00010;
    n0 = 0; n1 = 0; budget = 0;
    while (n0 + n1 < 20 && budget < 200) begin
      @(negedge clk);
      if (ack0[0]) n0++;
      if (ack1[0]) n1++;
      budget++;
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    chk("contend_ack0_count", n0, 10);
    chk("contend_ack1_count", n1, 10);
`else
    chk("contend_ack0_count", n0, 20);
    chk("contend_ack1_count", n1, 0);
`endif

    // Request dropped one cycle after grant still completes, then nothing more.
    @(negedge clk);
    issue(0, 0, 1'b1, 19'h00011, 16'h5A5A);
    @(negedge clk);
    req0[0] = 1'b0;
    wait_ack(0, 0);
    cs_lo = 0;
    repeat (10) begin
      @(negedge clk);
      if (!cs_n[0]) cs_lo++;
    end
    chk("drop_no_second_access", cs_lo, 0);

    // Reset in the middle of a write access.
    @(negedge clk);
    issue(0, 0, 1'b1, 19'h00012, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_we_n_low", we_n[0], 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we_n", we_n[0], 1);
    chk("mid_rst_cs_n", cs_n[0], 1);
    chk("mid_rst_oe_n", oe_n[0], 1);
    chk("mid_rst_dat_oe", sram_dat_oe[0], 0);
    req0[0] = 1'b0;
    for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].inst == 0) sb.delete(k);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_acc(0, 0, 1'b0, 19'h00010, 16'hA5A5);

    // Minimum and maximum wait states.
    do_acc(1, 0, 1'b1, 19'h00007, 16'h1111);
    do_acc(1, 1, 1'b0, 19'h00007, 16'h1111);
    do_acc(2, 0, 1'b1, 19'h00007, 16'hBEEF);
    do_acc(2, 1, 1'b0, 19'h00007, 16'hBEEF);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and cycle sequencer for the board's external 512K×16 asynchronous SRAM. It shares the single SRAM bus between two on-chip requesters, for example a button/DIP-driven logger and a PMOD display scanner. It generates CS/OE/WE strobes with a configurable number of wait states at the 100 MHz system clock. It sits directly below the top level, which owns the DAT tri-state buffer and the pin mapping.

## Interface
Parameters:
- WAIT_CYCLES, 2: SRAM strobe width in clk cycles; legal range 1..15; 0 is illegal (elaboration error).
- ADDR_W, 19: SRAM address width.
- DATA_W, 16: SRAM data width.

Ports:
- clk  in  1  100 MHz system clock; one clock domain; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request from port 0 / 1; held high until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data, shared by both ports; valid in the ack cycle; held until the next read completes.
- sram_adr  out  ADDR_W  SRAM address.
- sram_dat_out  out  DATA_W  data to the SRAM.
- sram_dat_oe  out  1  top-level tri-state enable for DAT.
- sram_dat_in  in  DATA_W  data from the SRAM pads.
- sram_cs_n, sram_oe_n, sram_we_n  out  1  active-low SRAM strobes.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req is high, grant one port.
  - Latch the granted port's we, addr and wdata into internal registers, then go to SETUP.
  - Later changes on the requester inputs have no effect on the access.
- SETUP (1 cycle):
  - sram_adr = latched address; sram_cs_n = 0.
  - Read: sram_oe_n = 0.
  - Write: sram_dat_oe = 1, sram_dat_out = latched wdata.
  - sram_we_n stays 1.
- ACCESS (WAIT_CYCLES cycles, counted by a down-counter):
  - Write: sram_we_n = 0.
  - Read: sram_dat_in is registered into rdata on the edge leaving the last ACCESS cycle.
- DONE (1 cycle):
  - sram_we_n = 1, sram_oe_n = 1, sram_cs_n = 1.
  - Write: sram_adr and sram_dat_oe held, giving data hold after WE rises.
  - Granted ack pulses high; next state IDLE.
- Arbitration (see Configuration): a last-grant pointer picks the winner when req0 and req1 are both high.
- Dropped request: if req falls after grant, the access still completes and ack still pulses. A requester that does not want a second access must drop req in the ack cycle.
- A request that rises in the same cycle as the other port's ack is considered in the following IDLE cycle.
- Reset values: ack0 = ack1 = 0, rdata = 0, sram_adr = 0, sram_dat_out = 0, sram_dat_oe = 0, sram_cs_n = sram_oe_n = sram_we_n = 1, state IDLE, pointer = 1.
- Reset mid-access: all strobes go inactive immediately (asynchronously), no ack is issued, and the access is lost.

## Timing
- req sampled in IDLE at edge k gives SETUP at k+1, ACCESS from k+2 to k+1+WAIT_CYCLES, and DONE (ack high) at k+2+WAIT_CYCLES.
- Latency from req to ack is WAIT_CYCLES+2 cycles.
- One mandatory IDLE turnaround cycle follows each access, so back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- With WAIT_CYCLES = 2: sram_we_n is low for 20 ns, address setup before WE is 10 ns, data hold after WE is 10 ns.
- sram_oe_n and sram_dat_oe are never both active; this is guaranteed by construction.
- All outputs are registered; no combinational path from any input to any SRAM pin.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. On contention, the port not granted last wins. The pointer updates on every grant.
- SRAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins. The pointer register is removed, and port 1 can be starved.

## Structure
- Package sram_arb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, DONE);
  - SRAM_ADDR_W = 19 and SRAM_DATA_W = 16;
  - reset constant for the strobe bundle (all 1).
- Sub-module sram_arb_grant:
  - purely combinational 2-way grant from req0, req1 and the pointer;
  - contains the SRAM_ARB_ROUND_ROBIN_EN conditional.
- The top module contains the FSM, wait counter, latches and output registers.

## Test plan
- Reset, then write 0xA5A5 to port 0 at address 0x00010 with WAIT_CYCLES = 2 -> ack0 pulses 4 cycles after req; sram_we_n is low for exactly 2 cycles; sram_dat_oe is high from SETUP through DONE.
- Port 1 reads address 0x00010 while an SRAM model returns 0xA5A5 -> ack1 pulses 4 cycles after req with rdata = 0xA5A5; sram_oe_n is low for 3 cycles; sram_dat_oe stays 0.
- req0 and req1 both held high for 20 accesses, with round-robin defined -> grants alternate starting with port 0, 10 acks each. Without the macro -> 20 ack0 and 0 ack1.
- Drop req0 one cycle after grant -> the access completes; ack0 still pulses once; no further access starts.
- Assert rst during ACCESS of a write -> sram_we_n, sram_cs_n and sram_oe_n go to 1 and sram_dat_oe goes to 0 before the next clock edge; no ack is issued; after rst is released, a new request completes normally.
- WAIT_CYCLES = 1 and 15 -> ack latency of 3 and 17 cycles respectively; the address never changes while sram_cs_n = 0.
